// File: rtl/zuc_pkg.sv
// Shared definitions for the 128-EEA3 request generator: state encodings,
// EEA3 field widths and the IV builder.
package zuc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CTL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int COUNT_W  = 32;
  localparam int BEARER_W = 5;
  localparam int WORD_W   = 32;
  localparam int NBITS_W  = 6;
  localparam int LEN_W    = 32;
  localparam int WLEFT_W  = 27;
  localparam int KEY_W    = 128;
  localparam int IV_W     = 128;

  // EEA3 IV: first 8 bytes are COUNT (big-endian), {BEARER,DIR,00}, three zero
  // bytes; the second 8 bytes repeat the first.
  function automatic logic [IV_W-1:0] eea3_iv(input logic [COUNT_W-1:0]  count,
                                               input logic [BEARER_W-1:0] bearer,
                                               input logic                dir);
    logic [63:0] half;
    half = {count, bearer, dir, 2'b00, 24'h000000};
    return {half, half};
  endfunction

endpackage

// File: rtl/zuc_eea3_req.sv
// 128-EEA3 request generator: one init (IV/key) transfer per message, then
// ceil(LENGTH/32) keystream-word requests tagged with their valid-bit count.
module zuc_eea3_req
  import zuc_pkg::*;
#(
  parameter int tw = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [KEY_W-1:0]      s_key,
  input  logic [COUNT_W-1:0]    s_count,
  input  logic [BEARER_W-1:0]   s_bearer,
  input  logic                  s_direction,
  input  logic [LEN_W-1:0]      s_length,
  input  logic [tw-1:0]         s_tag,
  output logic                  m_ctl_valid,
  input  logic                  m_ctl_ready,
  output logic [IV_W-1:0]       m_ctl_iv,
  output logic [KEY_W-1:0]      m_ctl_key,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [tw+NBITS_W-1:0] m_user
);

  logic [1:0]         state_q, state_d;
  logic [WLEFT_W-1:0] words_left_q, words_left_d;
  logic [4:0]         len_lo_q, len_lo_d;
  logic [IV_W-1:0]    iv_q, iv_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [tw-1:0]      tag_q, tag_d;

  logic               last_word;
  logic [NBITS_W-1:0] nbits;

  assign last_word = (words_left_q == '0);
  // Only the final word can be partial; a zero low field means a full word.
  assign nbits     = (last_word && (len_lo_q != 5'd0)) ? {1'b0, len_lo_q} : NBITS_W'(WORD_W);

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    len_lo_d     = len_lo_q;
    iv_d         = iv_q;
    key_d        = key_q;
    tag_d        = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && (s_length != '0)) begin
          key_d        = s_key;
          tag_d        = s_tag;
          len_lo_d     = s_length[4:0];
          iv_d         = eea3_iv(s_count, s_bearer, s_direction);
          // ceil(len/32) - 1 == (len - 1) / 32 for any non-zero len
          words_left_d = WLEFT_W'((s_length - 32'd1) >> 5);
          state_d      = ST_CTL;
        end
      end
      ST_CTL: begin
        if (m_ctl_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (m_ready) begin
          if (last_word) begin
            state_d = ST_IDLE;
          end else begin
            words_left_d = words_left_q - WLEFT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      len_lo_q     <= '0;
      iv_q         <= '0;
      key_q        <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      len_lo_q     <= len_lo_d;
      iv_q         <= iv_d;
      key_q        <= key_d;
      tag_q        <= tag_d;
    end
  end

  assign s_ready     = (state_q == ST_IDLE);
  assign m_ctl_valid = (state_q == ST_CTL);
  assign m_valid     = (state_q == ST_RUN);
  assign m_last      = (state_q == ST_RUN) && last_word;
  assign m_ctl_iv    = iv_q;
  assign m_ctl_key   = key_q;
  assign m_user      = {tag_q, nbits};

endmodule

// File: tb/tb_zuc_eea3_req.sv
// Directed and randomized bench for zuc_eea3_req against a byte-level IV model
// and a length-divided beat model.
module tb_zuc_eea3_req;

  localparam int TW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [127:0]    s_key = '0;
  logic [31:0]     s_count = '0;
  logic [4:0]      s_bearer = '0;
  logic            s_direction = 1'b0;
  logic [31:0]     s_length = '0;
  logic [TW-1:0]   s_tag = '0;
  logic            m_ctl_valid;
  logic            m_ctl_ready = 1'b0;
  logic [127:0]    m_ctl_iv;
  logic [127:0]    m_ctl_key;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            m_last;
  logic [TW+5:0]   m_user;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zuc_eea3_req #(.tw(TW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_count(s_count),
    .s_bearer(s_bearer), .s_direction(s_direction), .s_length(s_length), .s_tag(s_tag),
    .m_ctl_valid(m_ctl_valid), .m_ctl_ready(m_ctl_ready), .m_ctl_iv(m_ctl_iv), .m_ctl_key(m_ctl_key),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_user(m_user)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference IV assembled byte by byte.
  function automatic logic [127:0] model_iv(input logic [31:0] count, input logic [4:0] bearer,
                                            input logic dir);
    logic [7:0]   b [16];
    logic [127:0] r;
    b[0] = count[31:24]; b[1] = count[23:16]; b[2] = count[15:8]; b[3] = count[7:0];
    b[4] = {bearer, dir, 2'b00};
    b[5] = 8'h00; b[6] = 8'h00; b[7] = 8'h00;
    for (int i = 0; i < 8; i++) b[8+i] = b[i];
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_req(input logic [127:0] key, input logic [31:0] count, input logic [4:0] bearer,
                          input logic dir, input logic [31:0] len, input logic [TW-1:0] tag);
    int waited;
    waited = 0;
    while (s_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_key = key; s_count = count; s_bearer = bearer;
    s_direction = dir; s_length = len; s_tag = tag;
    @(negedge clk);
    s_valid = 1'b0;
    if (len != 0) begin
      chk("ctl_latency", m_ctl_valid, 1'b1);
    end else begin
      chk("len0_no_ctl", {m_ctl_valid, m_valid, s_ready}, 3'b001);
    end
  endtask

  task automatic do_ctl(input logic [127:0] exp_iv, input logic [127:0] exp_key, input int stall);
    for (int k = 0; k < stall; k++) begin
      m_ctl_ready = 1'b0;
      chk("ctl_hold_valid", {m_ctl_valid, m_valid, s_ready}, 3'b100);
      chk("ctl_hold_iv", m_ctl_iv, exp_iv);
      chk("ctl_hold_key", m_ctl_key, exp_key);
      @(negedge clk);
    end
    chk("ctl_valid", m_ctl_valid, 1'b1);
    chk("ctl_iv", m_ctl_iv, exp_iv);
    chk("ctl_key", m_ctl_key, exp_key);
    m_ctl_ready = 1'b1;
    @(negedge clk);
    m_ctl_ready = 1'b0;
    chk("first_beat_latency", {m_valid, m_ctl_valid}, 2'b10);
  endtask

  // bp: 0 always ready, 1 random ready, 2 ready toggling 1010...
  // stop_after >= 0 returns while beat index stop_after is being presented.
  task automatic run_beats(input logic [31:0] len, input logic [TW-1:0] tag, input int bp,
                           input int stop_after);
    longint n, i, rem;
    int idle, tog;
    logic rdy;
    logic [5:0] nb;
    n = (longint'(len) + 31) / 32;
    i = 0; idle = 0; tog = 0;
    while (i < n) begin
      if (stop_after >= 0 && i == longint'(stop_after) && m_valid === 1'b1) begin
        m_ready = 1'b0;
        return;
      end
      if (m_valid === 1'b1) begin
        idle = 0;
        rem = longint'(len) - 32 * i;
        nb = (rem > 32) ? 6'd32 : 6'(rem);
        chk("beat_user", m_user, {tag, nb});
        chk("beat_last", m_last, (i == n - 1));
        chk("beat_excl", {m_ctl_valid, s_ready}, 2'b00);
        case (bp)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom % 2);
          default: begin rdy = (tog % 2 == 0); tog++; end
        endcase
        m_ready = rdy;
        @(negedge clk);
        if (rdy) i++;
      end else begin
        m_ready = 1'b0;
        idle++;
        if (idle > 50) begin
          chk("beat_timeout", 1'b1, 1'b0);
          return;
        end
        @(negedge clk);
      end
    end
    m_ready = 1'b0;
    chk("done_ready", {s_ready, m_valid}, 2'b10);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", {m_valid, m_ctl_valid, m_last, s_ready}, 4'b0001);
    chk("rst_iv", m_ctl_iv, 128'h0);
    chk("rst_key", m_ctl_key, 128'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] key;
    logic [31:0]  cnt, len;
    logic [4:0]   br;
    logic         dr;
    logic [TW-1:0] tg;

    // Reset state
    #3;
    chk("reset_outputs", {m_valid, m_ctl_valid, m_last, s_ready}, 4'b0001);
    chk("reset_iv", m_ctl_iv, 128'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // EEA3 test set 1
    key = 128'h173d14ba5003731d7a60049470f00a29;
    send_req(key, 32'h398a59b4, 5'h15, 1'b1, 32'd193, 1'b0);
    do_ctl(128'h398a59b4ac000000398a59b4ac000000, key, 0);
    run_beats(32'd193, 1'b0, 0, -1);

    // LENGTH=64, ready toggling
    key = {$urandom, $urandom, $urandom, $urandom};
    send_req(key, 32'h01020304, 5'h03, 1'b0, 32'd64, 1'b1);
    do_ctl(model_iv(32'h01020304, 5'h03, 1'b0), key, 0);
    run_beats(32'd64, 1'b1, 2, -1);

    // Zero length is consumed silently, then a one-word message
    send_req(key, 32'hdeadbeef, 5'h1f, 1'b1, 32'd0, 1'b0);
    send_req(key, 32'hdeadbeef, 5'h1f, 1'b1, 32'd32, 1'b0);
    do_ctl(model_iv(32'hdeadbeef, 5'h1f, 1'b1), key, 0);
    run_beats(32'd32, 1'b0, 0, -1);

    // Ctl stalled for 10 cycles, single-bit message
    key = {$urandom, $urandom, $urandom, $urandom};
    send_req(key, 32'hcafef00d, 5'h0a, 1'b0, 32'd1, 1'b1);
    do_ctl(model_iv(32'hcafef00d, 5'h0a, 1'b0), key, 10);
    run_beats(32'd1, 1'b1, 0, -1);

    // Reset during beat 3 of a 320-bit message, then LENGTH=33
    send_req(key, 32'h11112222, 5'h05, 1'b1, 32'd320, 1'b0);
    do_ctl(model_iv(32'h11112222, 5'h05, 1'b1), key, 0);
    run_beats(32'd320, 1'b0, 0, 2);
    pulse_reset();
    send_req(key, 32'h33334444, 5'h06, 1'b0, 32'd33, 1'b1);
    do_ctl(model_iv(32'h33334444, 5'h06, 1'b0), key, 0);
    run_beats(32'd33, 1'b1, 0, -1);

    // Maximum length: check the opening beats then abandon via reset
    send_req(key, 32'hffffffff, 5'h00, 1'b1, 32'hffffffff, 1'b1);
    do_ctl(model_iv(32'hffffffff, 5'h00, 1'b1), key, 0);
    run_beats(32'hffffffff, 1'b1, 0, 3);
    pulse_reset();

    // Back-to-back messages with distinct tags
    for (int m = 0; m < 2; m++) begin
      tg = TW'(m);
      send_req(key, 32'h55aa0000 + 32'(m), 5'h11, 1'(m), 32'd96, tg);
      do_ctl(model_iv(32'h55aa0000 + 32'(m), 5'h11, 1'(m)), key, 0);
      run_beats(32'd96, tg, 0, -1);
    end

    // Randomized messages with random backpressure
    for (int r = 0; r < 8; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      cnt = $urandom;
      br  = 5'($urandom);
      dr  = 1'($urandom);
      tg  = TW'($urandom);
      len = (r % 3 == 0) ? 32 * $urandom_range(1, 6) : $urandom_range(1, 200);
      send_req(key, cnt, br, dr, len, tg);
      do_ctl(model_iv(cnt, br, dr), key, $urandom_range(0, 3));
      run_beats(len, tg, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
